// File: rtl/sram_level_loader.sv
// Purpose : streams bytes into 16-bit SRAM words (little-endian) and writes them
//           to consecutive word addresses starting at a captured base address.
// Ports   : Clk/Reset (async, active-high); start/base_addr/word_count request a load;
//           byte_data/byte_valid/byte_ready byte stream; SRAM_* async SRAM write port;
//           busy/done/words_written load status. All outputs are registered.
// Latency : 4+WE_CYCLES cycles per word with an unstalled stream; the stream may stall indefinitely.
module sram_level_loader #(
    parameter int WE_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [19:0] base_addr,
    input  logic [19:0] word_count,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [19:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_OUT,
    output logic        SRAM_DQ_OE,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        busy,
    output logic        done,
    output logic [19:0] words_written
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LO    = 3'd1,
        HI    = 3'd2,
        SETUP = 3'd3,
        WRITE = 3'd4,
        HOLD  = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t      state;
    state_t      nxt;
    logic [19:0] base_q;
    logic [19:0] count_q;
    logic [3:0]  we_cnt;
    logic        xfer;
    logic [19:0] ww_inc;

    // Next-cycle values of the registered outputs, decoded from the next state
    logic        n_ready;
    logic        n_dq_oe;
    logic        n_we_n;
    logic        n_busy;
    logic        n_done;

    assign xfer   = byte_valid & byte_ready;
    assign ww_inc = words_written + 20'd1;

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (start) nxt = (word_count == 20'd0) ? DONE : LO;
            LO:    if (xfer) nxt = HI;
            HI:    if (xfer) nxt = SETUP;
            SETUP: nxt = WRITE;
            WRITE: if (we_cnt == 4'(WE_CYCLES - 1)) nxt = HOLD;
            HOLD:  nxt = (ww_inc == count_q) ? DONE : LO;
            DONE:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Output decode: outputs are registered, so decode from the state being entered
    always_comb begin
        n_ready = (nxt == LO) || (nxt == HI);
        n_dq_oe = (nxt == SETUP) || (nxt == WRITE) || (nxt == HOLD);
        n_we_n  = (nxt != WRITE);
        n_busy  = (nxt != IDLE);
        n_done  = (nxt == DONE);
    end

    // Output registers and datapath
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            byte_ready    <= 1'b0;
            SRAM_ADDR     <= 20'd0;
            SRAM_DQ_OUT   <= 16'd0;
            SRAM_DQ_OE    <= 1'b0;
            SRAM_CE_N     <= 1'b1;
            SRAM_OE_N     <= 1'b1;
            SRAM_WE_N     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_written <= 20'd0;
            base_q        <= 20'd0;
            count_q       <= 20'd0;
            we_cnt        <= 4'd0;
        end else begin
            byte_ready <= n_ready;
            SRAM_DQ_OE <= n_dq_oe;
            SRAM_WE_N  <= n_we_n;
            SRAM_CE_N  <= ~n_busy;
            SRAM_OE_N  <= 1'b1;
            busy       <= n_busy;
            done       <= n_done;

            if (state == IDLE && start) begin
                base_q        <= base_addr;
                count_q       <= word_count;
                words_written <= 20'd0;
            end

            if (state == LO && xfer) SRAM_DQ_OUT[7:0]  <= byte_data;
            if (state == HI && xfer) SRAM_DQ_OUT[15:8] <= byte_data;

            // Address is latched once per word; 20-bit add wraps at the top of SRAM
            if (nxt == SETUP) SRAM_ADDR <= base_q + words_written;

            if (state == WRITE) we_cnt <= we_cnt + 4'd1;
            else                we_cnt <= 4'd0;

            // Only a word that completed its hold cycle is counted
            if (state == HOLD) words_written <= ww_inc;
        end
    end

endmodule

// File: tb/tb_sram_level_loader.sv
// Purpose : self-checking bench for sram_level_loader with a randomized byte stream.
// Ports   : none (top-level bench); drives Clk/Reset and all DUT inputs.
// Latency : expected writes come from the byte list and base+i address rule.
module tb_sram_level_loader;

    localparam int WE = 2;

    logic        Clk;
    logic        Reset;
    logic        start;
    logic [19:0] base_addr;
    logic [19:0] word_count;
    logic [7:0]  byte_data  = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [19:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_OUT;
    logic        SRAM_DQ_OE;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    logic        busy;
    logic        done;
    logic [19:0] words_written;

    sram_level_loader #(.WE_CYCLES(WE)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_OUT(SRAM_DQ_OUT),
        .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_WE_N(SRAM_WE_N), .busy(busy), .done(done), .words_written(words_written)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Byte source: test appends at src_wr, the stream consumer advances src_rd
    logic [7:0] src_mem [0:4095];
    int  src_wr = 0;
    int  src_rd = 0;
    bit  cont_mode = 1'b1;

    initial forever begin
        @(negedge Clk);
        if (Reset !== 1'b1 && src_rd < src_wr && (cont_mode || $urandom_range(0, 1) == 1)) begin
            byte_valid = 1'b1;
            byte_data  = src_mem[src_rd];
        end else begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
        end
    end

    initial forever begin
        @(posedge Clk);
        if (Reset === 1'b1)                src_rd = src_wr;  // reset discards pending bytes
        else if (byte_valid && byte_ready) src_rd = src_rd + 1;
    end

    // Bus monitor: reconstructs completed SRAM writes and counts protocol violations
    logic [19:0] cap_a [$];
    logic [15:0] cap_d [$];
    int  cyc = 0, viol = 0, nfall = 0, run = 0, done_cnt = 0, done_cyc = 0;
    int  busy_rise = 0, busy_cycles = 0;
    bit  prev_we = 1'b1, prev_busy = 1'b0;
    logic [19:0] wa = 20'd0;
    logic [15:0] wd = 16'd0;

    initial forever begin
        @(negedge Clk);
        cyc++;
        if (Reset === 1'b1) begin
            prev_we   = 1'b1;
            prev_busy = 1'b0;
        end else begin
            if (SRAM_OE_N !== 1'b1)   viol++;
            if (SRAM_CE_N !== ~busy)  viol++;
            if (byte_ready && SRAM_DQ_OE) viol++;
            if (busy && !prev_busy) busy_rise = cyc;
            if (busy) busy_cycles++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (SRAM_WE_N === 1'b0) begin
                if (SRAM_DQ_OE !== 1'b1 || SRAM_CE_N !== 1'b0) viol++;
                if (prev_we) begin
                    nfall++; run = 1; wa = SRAM_ADDR; wd = SRAM_DQ_OUT;
                end else begin
                    run++;
                    if (SRAM_ADDR !== wa || SRAM_DQ_OUT !== wd) viol++;
                end
            end else if (!prev_we) begin
                // hold cycle after a write strobe
                if (run != WE) viol++;
                if (SRAM_DQ_OE !== 1'b1 || SRAM_ADDR !== wa || SRAM_DQ_OUT !== wd) viol++;
                cap_a.push_back(wa);
                cap_d.push_back(wd);
            end
            prev_we   = (SRAM_WE_N === 1'b1);
            prev_busy = busy;
        end
    end

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        src_mem[src_wr] = b;
        src_wr++;
    endtask

    // One load; expected data = byte pairs little-endian, address = base+i mod 2^20
    task automatic do_load(input logic [19:0] base, input int cnt, input bit cont,
                           input bit midstart, input bit directed);
        int first, c0, nf0, dc0, bc0, t, budget;
        logic [19:0] ea;
        logic [15:0] ed;
        cont_mode = cont;
        if (directed) first = src_wr - 2 * cnt;
        else begin
            first = src_wr;
            for (int i = 0; i < 2 * cnt; i++) push_byte(8'($urandom));
        end
        c0 = cap_a.size(); nf0 = nfall; dc0 = done_cnt; bc0 = busy_cycles;
        base_addr = base; word_count = 20'(cnt); start = 1'b1;
        tick();
        start = 1'b0;
        base_addr = 20'($urandom); word_count = 20'($urandom);  // post-capture changes are ignored
        if (midstart) begin
            repeat (7) tick();
            start = 1'b1; base_addr = base ^ 20'h5A5A5; word_count = 20'd3;
            tick();
            start = 1'b0;
        end
        budget = 200 + cnt * 100;
        t = 0;
        while (done_cnt == dc0 && t < budget) begin tick(); t++; end
        chk("done_seen", 32'(done_cnt != dc0), 32'd1);
        repeat (3) tick();
        chk("done_pulses", 32'(done_cnt - dc0), 32'd1);
        chk("num_writes", 32'(cap_a.size() - c0), 32'(cnt));
        for (int i = 0; i < cnt; i++) begin
            if (c0 + i < cap_a.size()) begin
                ea = base + 20'(i);
                ed = {src_mem[first + 2 * i + 1], src_mem[first + 2 * i]};
                chk("wr_addr", 32'(cap_a[c0 + i]), 32'(ea));
                chk("wr_data", 32'(cap_d[c0 + i]), 32'(ed));
            end
        end
        chk("words_written", 32'(words_written), 32'(cnt));
        chk("busy_idle", 32'(busy), 32'd0);
        chk("bytes_consumed", 32'(src_rd), 32'(src_wr));
        chk("protocol_viol", 32'(viol), 32'd0);
        if (cont) chk("load_cycles", 32'(done_cyc - busy_rise), 32'(cnt * (4 + WE)));
        if (cnt == 0) begin
            chk("zero_busy_cyc", 32'(busy_cycles - bc0), 32'd1);
            chk("zero_no_we", 32'(nfall - nf0), 32'd0);
        end
    endtask

    initial begin
        int c0, nf0, dc0, t;
        logic [19:0] b;
        Reset = 1'b1; start = 1'b0; base_addr = 20'd0; word_count = 20'd0;
        repeat (3) tick();
        chk("rst_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("rst_ce_n", 32'(SRAM_CE_N), 32'd1);
        chk("rst_oe_n", 32'(SRAM_OE_N), 32'd1);
        chk("rst_dq_oe", 32'(SRAM_DQ_OE), 32'd0);
        chk("rst_addr", 32'(SRAM_ADDR), 32'd0);
        chk("rst_dq", 32'(SRAM_DQ_OUT), 32'd0);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ww", 32'(words_written), 32'd0);
        Reset = 1'b0;
        repeat (4) tick();
        chk("post_rst_ce_n", 32'(SRAM_CE_N), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Directed two-word load
        push_byte(8'h34); push_byte(8'h12); push_byte(8'h78); push_byte(8'h56);
        c0 = cap_a.size();
        do_load(20'h00100, 2, 1'b1, 1'b0, 1'b1);
        if (cap_a.size() >= c0 + 2) begin
            chk("dir_data0", 32'(cap_d[c0]), 32'h1234);
            chk("dir_addr0", 32'(cap_a[c0]), 32'h00100);
            chk("dir_data1", 32'(cap_d[c0 + 1]), 32'h5678);
            chk("dir_addr1", 32'(cap_a[c0 + 1]), 32'h00101);
        end else chk("dir_writes", 32'(cap_a.size() - c0), 32'd2);
        repeat (5) tick();
        chk("ww_holds", 32'(words_written), 32'd2);

        do_load(20'h12345, 0, 1'b1, 1'b0, 1'b0);

        // Address wrap
        c0 = cap_a.size();
        do_load(20'hFFFFF, 2, 1'b1, 1'b0, 1'b0);
        if (cap_a.size() >= c0 + 2) chk("wrap_addr", 32'(cap_a[c0 + 1]), 32'h00000);

        // Same 16-word content, continuous then with a stalling stream
        b = 20'($urandom);
        for (int i = 0; i < 32; i++) src_mem[src_wr + i] = 8'($urandom);
        for (int i = 0; i < 32; i++) src_mem[src_wr + 32 + i] = src_mem[src_wr + i];
        src_wr += 32;
        do_load(b, 16, 1'b1, 1'b0, 1'b1);
        src_wr += 32;
        do_load(b, 16, 1'b0, 1'b0, 1'b1);

        // Start pulsed mid-load must be ignored
        do_load(20'h0ABCD, 4, 1'b1, 1'b1, 1'b0);

        for (int k = 0; k < 6; k++)
            do_load(20'($urandom), $urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'b0, 1'b0);

        // Reset during the second WRITE cycle of word 3
        cont_mode = 1'b1;
        for (int i = 0; i < 10; i++) push_byte(8'($urandom));
        c0 = cap_a.size(); nf0 = nfall; dc0 = done_cnt;
        base_addr = 20'($urandom); word_count = 20'd5; start = 1'b1;
        tick();
        start = 1'b0;
        t = 0;
        while (!(nfall - nf0 == 3 && run == 1 && SRAM_WE_N === 1'b0) && t < 500) begin tick(); t++; end
        chk("abort_reached", 32'(t < 500), 32'd1);
        @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        chk("abort_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("abort_ce_n", 32'(SRAM_CE_N), 32'd1);
        chk("abort_dq_oe", 32'(SRAM_DQ_OE), 32'd0);
        chk("abort_ww", 32'(words_written), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (2) tick();
        Reset = 1'b0;
        repeat (10) tick();
        chk("abort_writes", 32'(cap_a.size() - c0), 32'd2);
        chk("abort_no_done", 32'(done_cnt - dc0), 32'd0);
        chk("abort_idle_ce", 32'(SRAM_CE_N), 32'd1);
        chk("abort_idle_we", 32'(nfall - nf0), 32'd3);

        // Loader works normally after the abort
        do_load(20'h00200, 3, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
